// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
//
// Sequential instruction fetch stage. Owns the architectural fetch PC, issues
// one instruction-memory request at a time, and buffers returned words in a
// small FIFO tagged with their PC and predicted next PC for the decode stage.
// Redirects from execute/commit flush the FIFO and discard any in-flight
// response.
//
// Optional feature macro: FETCH_BPRED_EN
//   defined   -> static prediction (JAL taken, backward branches taken)
//   undefined -> predicted next PC is always pc + 4
//
// Ports:
//   clk, rst            clock (rising edge), synchronous active-high reset
//   redirect_valid/pc   flush and restart fetch at redirect_pc
//   imem_req_*          request channel (valid/ready, address = fetch PC)
//   imem_resp_*         response channel (one cycle per accepted request)
//   fetch_o_*           queue head towards decode (valid, instr, pc,
//                       pc + 4, predicted next pc)
//   decode_i_ready      decode consumes the queue head
// ---------------------------------------------------------------------------
module fetch_unit #(
    parameter int unsigned     XLEN        = 64,
    parameter int unsigned     ILEN        = 32,
    parameter logic [XLEN-1:0] RESET_PC    = XLEN'(64'h8000_0000),
    parameter int unsigned     QUEUE_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_resp_valid,
    input  logic [ILEN-1:0] imem_resp_data,
    output logic            fetch_o_valid,
    input  logic            decode_i_ready,
    output logic [ILEN-1:0] fetch_o_instr,
    output logic [XLEN-1:0] fetch_o_pc,
    output logic [XLEN-1:0] fetch_o_pc_plus_4,
    output logic [XLEN-1:0] fetch_o_pre_pc
);

    localparam int unsigned PTR_W = $clog2(QUEUE_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(QUEUE_DEPTH);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_DROP = 2'd2;

    logic [1:0]       state_q,    state_d;
    logic [XLEN-1:0]  fetch_pc_q, fetch_pc_d;
    logic [PTR_W-1:0] wr_ptr_q,   wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q,   rd_ptr_d;
    logic [CNT_W-1:0] count_q,    count_d;

    logic [ILEN-1:0]  q_instr_q [QUEUE_DEPTH];
    logic [ILEN-1:0]  q_instr_d [QUEUE_DEPTH];
    logic [XLEN-1:0]  q_pc_q    [QUEUE_DEPTH];
    logic [XLEN-1:0]  q_pc_d    [QUEUE_DEPTH];
    logic [XLEN-1:0]  q_pre_q   [QUEUE_DEPTH];
    logic [XLEN-1:0]  q_pre_d   [QUEUE_DEPTH];

    logic [XLEN-1:0]  pre_pc;
    logic             handshake;
    logic             push;
    logic             pop;

    // Next-PC prediction for the word currently on the response bus.
`ifdef FETCH_BPRED_EN
    logic [6:0]      resp_opcode;
    logic [XLEN-1:0] j_imm;
    logic [XLEN-1:0] b_imm;

    assign resp_opcode = imem_resp_data[6:0];
    assign j_imm = {{(XLEN-21){imem_resp_data[31]}}, imem_resp_data[31],
                    imem_resp_data[19:12], imem_resp_data[20],
                    imem_resp_data[30:21], 1'b0};
    assign b_imm = {{(XLEN-13){imem_resp_data[31]}}, imem_resp_data[31],
                    imem_resp_data[7], imem_resp_data[30:25],
                    imem_resp_data[11:8], 1'b0};

    // JAL is always taken; conditional branches are taken only when the
    // offset is negative (loop-closing branch heuristic).
    always_comb begin
        pre_pc = fetch_pc_q + XLEN'(4);
        if (resp_opcode == 7'b1101111) begin
            pre_pc = fetch_pc_q + j_imm;
        end else if (resp_opcode == 7'b1100011 && imem_resp_data[31]) begin
            pre_pc = fetch_pc_q + b_imm;
        end
    end
`else
    assign pre_pc = fetch_pc_q + XLEN'(4);
`endif

    // A request is only offered when nothing is in flight and the queue has
    // room, so every response is guaranteed a slot. Redirect and reset
    // suppress the request so no handshake can coincide with a flush.
    assign imem_req_valid = (state_q == ST_IDLE) && (count_q < DEPTH_C)
                            && !redirect_valid && !rst;
    assign imem_req_addr  = fetch_pc_q;
    assign handshake      = imem_req_valid && imem_req_ready;

    // Head of queue is read from registered storage only; zeros when empty.
    assign fetch_o_valid     = (count_q != '0);
    assign fetch_o_instr     = fetch_o_valid ? q_instr_q[rd_ptr_q] : '0;
    assign fetch_o_pc        = fetch_o_valid ? q_pc_q[rd_ptr_q] : '0;
    assign fetch_o_pc_plus_4 = fetch_o_valid ? (q_pc_q[rd_ptr_q] + XLEN'(4)) : '0;
    assign fetch_o_pre_pc    = fetch_o_valid ? q_pre_q[rd_ptr_q] : '0;

    // Next-state logic: request FSM, fetch PC and FIFO bookkeeping. Redirect
    // wins over everything: the queue is cleared, any pop or same-cycle
    // response is ignored, and an outstanding request turns into DROP so its
    // response is thrown away when it eventually arrives.
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        q_instr_d  = q_instr_q;
        q_pc_d     = q_pc_q;
        q_pre_d    = q_pre_q;
        push       = 1'b0;
        pop        = 1'b0;

        if (redirect_valid) begin
            fetch_pc_d = redirect_pc;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            // Nothing is in flight from IDLE (the request is suppressed), and
            // a response landing this very cycle closes the outstanding one.
            if (state_q == ST_IDLE || imem_resp_valid) begin
                state_d = ST_IDLE;
            end else begin
                state_d = ST_DROP;
            end
        end else begin
            pop = fetch_o_valid && decode_i_ready;
            case (state_q)
                ST_IDLE: begin
                    if (handshake) begin
                        state_d = ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (imem_resp_valid) begin
                        push       = 1'b1;
                        fetch_pc_d = pre_pc;
                        state_d    = ST_IDLE;
                    end
                end
                ST_DROP: begin
                    if (imem_resp_valid) begin
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase

            if (push) begin
                q_instr_d[wr_ptr_q] = imem_resp_data;
                q_pc_d[wr_ptr_q]    = fetch_pc_q;
                q_pre_d[wr_ptr_q]   = pre_pc;
                wr_ptr_d            = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            if (push && !pop) begin
                count_d = count_q + 1'b1;
            end else if (pop && !push) begin
                count_d = count_q - 1'b1;
            end
        end
    end

    // Control state with synchronous reset; dropping state to IDLE also
    // forgets any outstanding request, so a late response is ignored.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            fetch_pc_q <= RESET_PC;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

    // Queue payload storage; never reset because the outputs are masked
    // whenever the queue is empty.
    always_ff @(posedge clk) begin
        q_instr_q <= q_instr_d;
        q_pc_q    <= q_pc_d;
        q_pre_q   <= q_pre_d;
    end

endmodule

// File: tb/tb_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_fetch_unit
//
// Self-checking bench for fetch_unit. A queue-based reference model tracks
// the expected fetch PC, the expected queue contents and whether a memory
// request is outstanding (and whether its response must be discarded). A
// simple memory model answers accepted requests after a configurable latency.
// Directed scenarios are followed by a randomized phase.
// ---------------------------------------------------------------------------
module tb_fetch_unit;

    localparam int          XLEN     = 64;
    localparam int          ILEN     = 32;
    localparam int          DEPTH    = 4;
    localparam logic [63:0] RESET_PC = 64'h8000_0000;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] instr;
        logic [63:0] pre;
    } entry_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [63:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        fetch_o_valid;
    logic        decode_i_ready;
    logic [31:0] fetch_o_instr;
    logic [63:0] fetch_o_pc;
    logic [63:0] fetch_o_pc_plus_4;
    logic [63:0] fetch_o_pre_pc;

    // Reference model state
    entry_t      model_q[$];
    logic [63:0] model_pc;
    bit          model_busy;
    bit          model_discard;
    bit          model_init;

    // Memory model state
    int          mem_wait;
    int          mem_latency;
    bit          mem_directed;
    logic [63:0] mem_addr;

    // Observation logs and last sampled outputs
    logic [63:0] req_log[$];
    entry_t      pop_log[$];
    logic        obs_req_valid;
    logic [63:0] obs_req_addr;
    logic        obs_fetch_valid;

    int checks;
    int failures;

    always #5 clk = ~clk;

    fetch_unit #(
        .XLEN(XLEN),
        .ILEN(ILEN),
        .RESET_PC(RESET_PC),
        .QUEUE_DEPTH(DEPTH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc),
        .imem_req_valid(imem_req_valid),
        .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_resp_valid(imem_resp_valid),
        .imem_resp_data(imem_resp_data),
        .fetch_o_valid(fetch_o_valid),
        .decode_i_ready(decode_i_ready),
        .fetch_o_instr(fetch_o_instr),
        .fetch_o_pc(fetch_o_pc),
        .fetch_o_pc_plus_4(fetch_o_pc_plus_4),
        .fetch_o_pre_pc(fetch_o_pre_pc)
    );

    // Predicted next PC from the ISA immediate definitions, using signed
    // integer arithmetic rather than bit-level sign extension.
    function automatic logic [63:0] predict(input logic [63:0] pc, input logic [31:0] w);
        longint off;
        off = 4;
`ifdef FETCH_BPRED_EN
        if (w[6:0] == 7'b1101111) begin
            off = longint'($signed({w[31], w[19:12], w[20], w[30:21], 1'b0}));
        end else if (w[6:0] == 7'b1100011 && w[31]) begin
            off = longint'($signed({w[31], w[7], w[30:25], w[11:8], 1'b0}));
        end
`endif
        return pc + 64'(off);
    endfunction

    // Directed program image: one backward branch at 0x8000_0008, nops elsewhere.
    function automatic logic [31:0] mem_word(input logic [63:0] addr);
        return (addr == 64'h8000_0008) ? 32'hFE00_0EE3 : 32'h0000_0013;
    endfunction

    // One comparison point: counts the check, asserts equality, reports on failure.
    task automatic check64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Compare every DUT output against the reference model for this cycle.
    task automatic checkOutput(input bit exp_req);
        entry_t head;
        head = '0;
        if (model_q.size() != 0) head = model_q[0];
        check64("fetch_o_valid", {63'b0, fetch_o_valid}, {63'b0, model_q.size() != 0});
        check64("fetch_o_instr", {32'b0, fetch_o_instr}, {32'b0, head.instr});
        check64("fetch_o_pc", fetch_o_pc, head.pc);
        check64("fetch_o_pc_plus_4", fetch_o_pc_plus_4, (model_q.size() != 0) ? head.pc + 64'd4 : 64'd0);
        check64("fetch_o_pre_pc", fetch_o_pre_pc, head.pre);
        check64("imem_req_valid", {63'b0, imem_req_valid}, {63'b0, exp_req});
        check64("imem_req_addr", imem_req_addr, model_pc);
    endtask

    // Run one clock cycle: drive inputs, check outputs mid-cycle, advance
    // the memory and reference models across the rising edge.
    task automatic applyStimulus(input bit rst_v, input bit redir_v, input logic [63:0] redir_pc_v,
                                 input bit req_ready_v, input bit dec_ready_v);
        bit          resp_v;
        logic [31:0] data_v;
        bit          exp_req;
        entry_t      e;

        resp_v = 1'b0;
        if (mem_wait > 0) begin
            mem_wait--;
            resp_v = (mem_wait == 0);
        end
        data_v = mem_directed ? mem_word(mem_addr) : $urandom;

        rst             = rst_v;
        redirect_valid  = redir_v;
        redirect_pc     = redir_pc_v;
        imem_req_ready  = req_ready_v;
        decode_i_ready  = dec_ready_v;
        imem_resp_valid = resp_v;
        imem_resp_data  = data_v;

        @(negedge clk);
        exp_req = !rst_v && !redir_v && !model_busy && (model_q.size() < DEPTH);
        if (model_init) checkOutput(exp_req);

        obs_req_valid   = imem_req_valid;
        obs_req_addr    = imem_req_addr;
        obs_fetch_valid = fetch_o_valid;
        if (imem_req_valid && req_ready_v) begin
            req_log.push_back(imem_req_addr);
            mem_wait = mem_latency;
            mem_addr = imem_req_addr;
        end
        if (fetch_o_valid && dec_ready_v && !redir_v && !rst_v) begin
            pop_log.push_back('{pc: fetch_o_pc, instr: fetch_o_instr, pre: fetch_o_pre_pc});
        end

        @(posedge clk);
        #1;
        if (rst_v) begin
            model_q.delete();
            model_pc      = RESET_PC;
            model_busy    = 1'b0;
            model_discard = 1'b0;
            model_init    = 1'b1;
        end else if (redir_v) begin
            model_q.delete();
            model_pc = redir_pc_v;
            if (model_busy) begin
                if (resp_v) begin
                    model_busy    = 1'b0;
                    model_discard = 1'b0;
                end else begin
                    model_discard = 1'b1;
                end
            end
        end else begin
            if (model_q.size() != 0 && dec_ready_v) e = model_q.pop_front();
            if (model_busy && resp_v) begin
                if (!model_discard) begin
                    e = '{pc: model_pc, instr: data_v, pre: predict(model_pc, data_v)};
                    model_q.push_back(e);
                    model_pc = e.pre;
                end
                model_busy    = 1'b0;
                model_discard = 1'b0;
            end else if (exp_req && req_ready_v) begin
                model_busy = 1'b1;
            end
        end
    endtask

    task automatic do_reset();
        applyStimulus(1, 0, 64'd0, 0, 0);
        applyStimulus(1, 0, 64'd0, 0, 0);
        req_log.delete();
        pop_log.delete();
    endtask

    initial begin
        logic [63:0] exp_next;
        logic [63:0] rpc;
        checks         = 0;
        failures       = 0;
        model_init     = 1'b0;
        model_busy     = 1'b0;
        model_discard  = 1'b0;
        model_pc       = RESET_PC;
        mem_wait       = 0;
        mem_latency    = 1;
        mem_directed   = 1'b0;
        mem_addr       = '0;
        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        imem_req_ready = 1'b0;
        decode_i_ready = 1'b0;
        imem_resp_valid = 1'b0;
        imem_resp_data = '0;
        @(posedge clk);
        #1;

        // Streaming with a 1-cycle memory and decode always ready
        do_reset();
        for (int i = 0; i < 8; i++) applyStimulus(0, 0, 64'd0, 1, 1);
        check64("stream_req0", req_log[0], 64'h8000_0000);
        check64("stream_req1", req_log[1], 64'h8000_0004);
        check64("stream_req2", req_log[2], 64'h8000_0008);
        check64("stream_pop0_pc", pop_log[0].pc, 64'h8000_0000);
        check64("stream_pop1_pc", pop_log[1].pc, 64'h8000_0004);
        check64("stream_pop2_pc", pop_log[2].pc, 64'h8000_0008);

        // Fill the queue with decode stalled, then release one slot
        do_reset();
        for (int i = 0; i < 12; i++) applyStimulus(0, 0, 64'd0, 1, 0);
        check64("full_req_count", 64'(req_log.size()), 64'd4);
        check64("full_req_valid", {63'b0, obs_req_valid}, 64'd0);
        applyStimulus(0, 0, 64'd0, 1, 1);
        for (int i = 0; i < 6; i++) applyStimulus(0, 0, 64'd0, 1, 0);
        check64("full_one_more_req", 64'(req_log.size()), 64'd5);
        check64("full_next_addr", req_log[4], 64'h8000_0010);
        check64("full_pop_pc", pop_log[0].pc, 64'h8000_0000);

        // Redirect while waiting on a slow response, then a stalled request
        do_reset();
        mem_latency = 4;
        applyStimulus(0, 0, 64'd0, 1, 1);
        applyStimulus(0, 1, 64'h8000_1000, 1, 1);
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 64'd0, 0, 1);
        check64("redir_queue_empty", {63'b0, obs_fetch_valid}, 64'd0);
        mem_latency = 1;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(0, 0, 64'd0, 0, 1);
            check64("stall_req_valid", {63'b0, obs_req_valid}, 64'd1);
            check64("stall_req_addr", obs_req_addr, 64'h8000_1000);
        end
        check64("stall_no_push", 64'(pop_log.size()), 64'd0);
        applyStimulus(0, 0, 64'd0, 1, 1);
        check64("redir_next_req", req_log[1], 64'h8000_1000);

        // Backward branch at 0x8000_0008
        do_reset();
        mem_directed = 1'b1;
        for (int i = 0; i < 10; i++) applyStimulus(0, 0, 64'd0, 1, 1);
`ifdef FETCH_BPRED_EN
        exp_next = 64'h8000_0004;
`else
        exp_next = 64'h8000_000C;
`endif
        check64("bpred_head_pc", pop_log[2].pc, 64'h8000_0008);
        check64("bpred_pre_pc", pop_log[2].pre, exp_next);
        check64("bpred_next_req", req_log[3], exp_next);
        mem_directed = 1'b0;

        // Reset while waiting with two queued entries; stale response ignored
        do_reset();
        for (int i = 0; i < 4; i++) applyStimulus(0, 0, 64'd0, 1, 0);
        mem_latency = 3;
        applyStimulus(0, 0, 64'd0, 1, 0);
        applyStimulus(1, 0, 64'd0, 0, 0);
        applyStimulus(0, 0, 64'd0, 0, 0);
        check64("rst_fetch_valid", {63'b0, obs_fetch_valid}, 64'd0);
        check64("rst_req_addr", obs_req_addr, RESET_PC);
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 64'd0, 0, 0);
        check64("rst_stale_ignored", {63'b0, obs_fetch_valid}, 64'd0);
        mem_latency = 1;
        req_log.delete();
        for (int i = 0; i < 4; i++) applyStimulus(0, 0, 64'd0, 1, 1);
        check64("rst_first_req", req_log[0], RESET_PC);

        // Randomized traffic with redirects, including PC wrap-around
        do_reset();
        for (int i = 0; i < 400; i++) begin
            mem_latency = int'($urandom_range(1, 3));
            if ($urandom_range(0, 15) == 0) begin
                case ($urandom_range(0, 2))
                    0:       rpc = 64'hFFFF_FFFF_FFFF_FFF8;
                    1:       rpc = 64'h8000_2000;
                    default: rpc = {$urandom, $urandom} & ~64'h3;
                endcase
                applyStimulus(0, 1, rpc, $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 6);
            end else begin
                applyStimulus(0, 0, 64'd0, $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 6);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
